digit_scan_sequencer: RTL and testbench
=======================================

// Module: digit_scan_sequencer
// PURPOSE
//  - Time-multiplexed scan source for a 4-way one-hot select path.
//  - Produces the 2-bit index that feeds the 2-to-4 decoder stage (de2to4.in), one digit at a time.
//  - Programmable dwell per digit, blanking gap between digits, and a per-digit enable mask.
//  - Signals each completed frame to upstream logic.
// PARAMETERS
//  - DWELL  default 4  cycles sel_valid is held high per digit; legal range 1..65535.
//  - BLANK  default 1  cycles sel_valid is low between digits; legal range 0..65535.
//  - CNT_W  default 16 width of the shared dwell/blank counter.
// PORTS
//  - clk         in   1  single clock; all state updates on the rising edge.
//  - rst         in   1  synchronous, active-high reset.
//  - en          in   1  scan enable; level-sensitive.
//  - digit_mask  in   4  bit i=1 means digit i is scanned; sampled only at digit boundaries.
//  - sel         out  2  current digit index, to the decoder.
//  - sel_valid   out  1  high while sel is being driven (dwell); low in IDLE/BLANK.
//  - frame_done  out  1  one-cycle pulse; see BEHAVIOUR.
// BEHAVIOUR
//  - Reset: state=IDLE, sel=2'b00, sel_valid=0, frame_done=0, counter=0.
//    Reset overrides everything, including mid-dwell or mid-blank.
//  - All outputs are registered.
//  - FSM states: IDLE, DWELL, BLANK.
//  - IDLE
//    - sel holds its last value; sel_valid=0.
//    - If en=1 and digit_mask!=0: next cycle enter DWELL with sel = lowest set mask bit and counter=0.
//    - Latency from en rising to sel_valid=1 is exactly 1 cycle.
//  - DWELL
//    - sel_valid=1; counter increments each cycle.
//    - The cycle with counter==DWELL-1 is the boundary cycle: next index = next set mask bit above sel, wrapping 3->0.
//    - With a single set bit, the next index is sel itself.
//    - Mask is sampled only on the boundary cycle.
//    - At the boundary, if the sampled mask==0 -> IDLE.
//    - Else if BLANK==0 -> DWELL with the new sel, counter=0. sel_valid stays 1 with no gap.
//    - Else -> BLANK with counter=0. sel keeps the old value during BLANK.
//  - BLANK
//    - sel_valid=0 for BLANK cycles.
//    - Then DWELL with the index computed at the preceding boundary.
//  - frame_done
//    - Registered, so it is high on the first cycle after a boundary cycle whose next index <= current sel (wrap).
//    - It therefore coincides with the first BLANK cycle, or with the first DWELL cycle of the new frame when BLANK==0.
//    - With a single enabled digit it pulses once per digit period.
//  - en=0 in DWELL or BLANK: IDLE on the next cycle and sel_valid=0 on the next cycle.
//    - No frame_done is produced on this abort.
//    - en=1 on a later cycle restarts from the lowest set bit.
//  - Mask changes outside boundary cycles have no effect until the next boundary.
//  - Simultaneous en=0 and boundary cycle: en=0 wins, go to IDLE.
//  - Counter compare uses CNT_W bits and never wraps within legal parameter ranges.
// STRUCTURE
//  - Shared package scan_pkg holds:
//    - the state encoding localparams (IDLE=2'd0, DWELL=2'd1, BLANK=2'd2);
//    - NUM_DIGITS=4;
//    - SEL_W=2.
//  - One combinational sub-module, scan_next_sel:
//    - inputs cur_sel[1:0] and mask[3:0];
//    - outputs nxt_sel[1:0] and wrap (nxt_sel <= cur_sel).
//  - FSM, counter and output registers live in the top module.
// TESTING
//  - Unless noted, DWELL=4, BLANK=1; en and mask are held from cycle 0, and the first DWELL cycle is cycle 1.
//  - T1 mask=4'b1111, en=1 at cycle 0:
//    - sel=0 valid cycles 1-4, blank at 5, sel=1 at 6-9, ... sel=3 at 16-19;
//    - frame_done at cycle 20 (first blank after sel=3), then again every 20 cycles.
//  - T2 mask=4'b0101:
//    - sel alternates 0,2,0,2 with 4-valid/1-blank;
//    - frame_done on the first blank cycle after each sel=2 dwell, every 10 cycles.
//  - T3 mask=4'b0100:
//    - sel stays 2, sel_valid pattern 1111 0 repeating;
//    - frame_done on every blank cycle.
//  - T4 DWELL=3, BLANK=0, mask=4'b1010:
//    - sel_valid constantly 1 after start, sel 1,1,1,3,3,3,1,...;
//    - frame_done on the first cycle of each sel=1 dwell after a sel=3 dwell.
//  - T5 mask 1111 -> 0000 at cycle 2:
//    - sel=0 dwell completes through cycle 4;
//    - cycle 5 is IDLE with sel_valid=0 and no frame_done.
//    - Separately, en=0 at cycle 7 (mid sel=1 dwell): sel_valid=0 from cycle 8.
//  - T6 rst=1 for one cycle mid-dwell (sel=2):
//    - next cycle sel=0, sel_valid=0, frame_done=0;
//    - with en still 1 after rst falls, sel=0 valid one cycle later.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the digit scan sequencer.
//   - State encoding for the scan FSM (IDLE/DWELL/BLANK) and the enum built on it.
//   - NUM_DIGITS / SEL_W sizing constants for the 4-way select path.
//   - lowest_set(): index of the lowest set bit of a digit mask (0 for an empty mask).
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DWELL = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_DWELL = DWELL,
    ST_BLANK = BLANK
  } state_e;

  // Scanning downwards leaves the lowest set bit as the final assignment.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Combinational next-digit search.
//   cur_sel  in  SEL_W       digit currently being shown
//   mask     in  NUM_DIGITS  enabled digits
//   nxt_sel  out SEL_W       next enabled digit above cur_sel, wrapping 3->0;
//                            cur_sel itself if it is the only enabled digit
//                            (or if mask is empty)
//   wrap     out 1           nxt_sel <= cur_sel, i.e. the scan restarted a frame
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]      cur_sel,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      nxt_sel,
  output logic                  wrap
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Try offsets 1..NUM_DIGITS from cur_sel; offset NUM_DIGITS lands back on
  // cur_sel, which covers the single-enabled-digit case.
  always_comb begin
    nxt_sel = cur_sel;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      idx = cur_sel + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt_sel = idx;
        found   = 1'b1;
      end
    end
    wrap = (nxt_sel <= cur_sel);
  end

endmodule

// File: rtl/digit_scan_sequencer.sv
// Time-multiplexed scan source for a 4-way one-hot select path.
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset
//   en          in   1  scan enable (level)
//   digit_mask  in   4  digit i scanned when bit i is set; sampled at digit boundaries
//   sel         out  2  current digit index for the 2-to-4 decoder
//   sel_valid   out  1  high during a digit's dwell
//   frame_done  out  1  one-cycle pulse after the boundary that wraps the scan
//   state_dbg   out  2  current FSM state (IDLE=0, DWELL=1, BLANK=2)
// All outputs are registered. One CNT_W counter is shared by dwell and blank.
module digit_scan_sequencer
  import scan_pkg::state_e, scan_pkg::ST_IDLE, scan_pkg::ST_DWELL, scan_pkg::ST_BLANK,
         scan_pkg::SEL_W, scan_pkg::NUM_DIGITS, scan_pkg::lowest_set;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic                  frame_done,
  output logic [1:0]            state_dbg
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // BLANK==0 never enters the blank state, so its compare value is irrelevant.
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;   // index to show after the current blank
  logic             valid_q, valid_d;
  logic             fd_q, fd_d;

  logic [SEL_W-1:0] step_sel;
  logic             step_wrap;

  scan_next_sel u_next_sel (
    .cur_sel (sel_q),
    .mask    (digit_mask),
    .nxt_sel (step_sel),
    .wrap    (step_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    fd_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && digit_mask != '0) begin
          state_d = ST_DWELL;
          sel_d   = lowest_set(digit_mask);
          cnt_d   = '0;
        end
      end
      ST_DWELL: begin
        // Dropping en takes priority over a coincident boundary.
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (digit_mask == '0) begin
            state_d = ST_IDLE;
          end else begin
            fd_d = step_wrap;
            if (BLANK == 0) begin
              sel_d = step_sel;
            end else begin
              state_d = ST_BLANK;
              pend_d  = step_sel;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_DWELL;
          sel_d   = pend_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    valid_d = (state_d == ST_DWELL);
  end

  assign sel        = sel_q;
  assign sel_valid  = valid_q;
  assign frame_done = fd_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: dut_a uses DWELL=4/BLANK=1, dut_b uses DWELL=3/BLANK=0.
module tb_digit_scan_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [3:0] mask_a, mask_b;
  logic [1:0] sel_a, sel_b, st_a, st_b;
  logic       val_a, val_b, fd_a, fd_b;

  digit_scan_sequencer #(.DWELL(4), .BLANK(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .digit_mask(mask_a),
    .sel(sel_a), .sel_valid(val_a), .frame_done(fd_a), .state_dbg(st_a)
  );

  digit_scan_sequencer #(.DWELL(3), .BLANK(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .digit_mask(mask_b),
    .sel(sel_b), .sel_valid(val_b), .frame_done(fd_b), .state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int cyc, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d exp %0d", name, cyc, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cyc, input int es, input int ev, input int ef);
    chk({tag, "_sel"}, cyc, int'(sel_a), es);
    chk({tag, "_valid"}, cyc, int'(val_a), ev);
    chk({tag, "_frame_done"}, cyc, int'(fd_a), ef);
  endtask

  task automatic chk_b(input string tag, input int cyc, input int es, input int ev, input int ef);
    chk({tag, "_sel"}, cyc, int'(sel_b), es);
    chk({tag, "_valid"}, cyc, int'(val_b), ev);
    chk({tag, "_frame_done"}, cyc, int'(fd_b), ef);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_a = 1'b1; en_a = 1'b0; mask_a = 4'h0;
    rst_b = 1'b1; en_b = 1'b0; mask_b = 4'h0;
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Tracks how many cycles remain in the current dwell or gap and which
  // digit is shown; next digit is found by walking the mask modulo 4.
  typedef struct {
    bit active;
    bit showing;
    int left;
    int sel;
    int upcoming;
    bit valid;
    bit fd;
  } mdl_t;

  function automatic int lowest(input logic [3:0] mk);
    for (int i = 0; i < 4; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_above(input int cur, input logic [3:0] mk);
    for (int d = 1; d <= 4; d++) if (mk[(cur + d) % 4]) return (cur + d) % 4;
    return cur;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.active = 0; n.showing = 0; n.left = 0; n.sel = 0;
    n.upcoming = 0; n.valid = 0; n.fd = 0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit e,
                                    input logic [3:0] mk, input int dwell, input int blank);
    mdl_t n;
    int   nx;
    n = m;
    n.fd = 0;
    if (r) return mdl_reset();
    if (!n.active) begin
      if (e && mk != 4'h0) begin
        n.active = 1; n.showing = 1; n.left = dwell; n.sel = lowest(mk); n.valid = 1;
      end else begin
        n.valid = 0;
      end
      return n;
    end
    if (!e) begin
      n.active = 0; n.valid = 0;
      return n;
    end
    if (n.left > 1) begin
      n.left--;
      return n;
    end
    if (n.showing) begin
      if (mk == 4'h0) begin
        n.active = 0; n.valid = 0;
      end else begin
        nx = next_above(n.sel, mk);
        n.fd = (nx <= n.sel);
        if (blank == 0) begin
          n.sel = nx; n.left = dwell;
        end else begin
          n.showing = 0; n.left = blank; n.upcoming = nx; n.valid = 0;
        end
      end
    end else begin
      n.showing = 1; n.sel = n.upcoming; n.left = dwell; n.valid = 1;
    end
    return n;
  endfunction

  function automatic int mdl_state(input mdl_t m);
    if (!m.active) return 0;
    return m.showing ? 1 : 2;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] mask;
    int         sel;
    bit         valid;
    bit         fd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit e, input logic [3:0] m,
                     input int s, input bit v, input bit f);
    vec_t x;
    x.rst = r; x.en = e; x.mask = m; x.sel = s; x.valid = v; x.fd = f;
    vt.push_back(x);
  endtask

  // ---------------- stimulus ----------------
  int   p, k;
  mdl_t ma, mb, na, nb;
  bit   ra, ea, rb, eb;

  initial begin
    // Reset state
    reset_all();
    chk_a("rst_a", 0, 0, 0, 0);
    chk("rst_a_state", 0, int'(st_a), 0);
    chk_b("rst_b", 0, 0, 0, 0);
    chk("rst_b_state", 0, int'(st_b), 0);

    // Table: mask emptied mid-dwell, en abort, restart, mask change ignored mid-dwell.
    // Each row: inputs during a cycle, expected outputs in the following cycle.
    add(1, 0, 4'h0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'h0, 0, 1, 0);
    add(0, 1, 4'h0, 0, 1, 0);
    add(0, 1, 4'h0, 0, 0, 0);
    add(0, 1, 4'h0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'hF, 0, 1, 0);
    add(0, 1, 4'hF, 0, 0, 0);
    add(0, 1, 4'hF, 1, 1, 0);
    add(0, 1, 4'hF, 1, 1, 0);
    add(0, 0, 4'hF, 1, 0, 0);
    add(0, 0, 4'hF, 1, 0, 0);
    add(0, 1, 4'h4, 2, 1, 0);
    add(0, 1, 4'h1, 2, 1, 0);
    add(0, 1, 4'h1, 2, 1, 0);
    add(0, 1, 4'h1, 2, 1, 0);
    add(0, 1, 4'h1, 2, 0, 1);
    add(0, 1, 4'h1, 0, 1, 0);
    foreach (vt[i]) begin
      rst_a = vt[i].rst; en_a = vt[i].en; mask_a = vt[i].mask;
      tick();
      chk_a("tbl", i, vt[i].sel, vt[i].valid, vt[i].fd);
    end

    // T1: all digits
    reset_all();
    en_a = 1'b1; mask_a = 4'hF;
    for (int n = 1; n <= 60; n++) begin
      tick();
      p = (n - 1) / 5; k = (n - 1) % 5;
      chk_a("t1", n, p % 4, (k < 4) ? 1 : 0, (n % 20 == 0) ? 1 : 0);
    end

    // T2: digits 0 and 2
    reset_all();
    en_a = 1'b1; mask_a = 4'b0101;
    for (int n = 1; n <= 40; n++) begin
      tick();
      p = (n - 1) / 5; k = (n - 1) % 5;
      chk_a("t2", n, (p % 2) * 2, (k < 4) ? 1 : 0, (n % 10 == 0) ? 1 : 0);
    end

    // T3: single digit 2
    reset_all();
    en_a = 1'b1; mask_a = 4'b0100;
    for (int n = 1; n <= 25; n++) begin
      tick();
      k = (n - 1) % 5;
      chk_a("t3", n, 2, (k < 4) ? 1 : 0, (n % 5 == 0) ? 1 : 0);
    end

    // T4: DWELL=3, BLANK=0, digits 1 and 3
    reset_all();
    en_b = 1'b1; mask_b = 4'b1010;
    for (int n = 1; n <= 36; n++) begin
      tick();
      p = (n - 1) / 3;
      chk_b("t4", n, (p % 2 == 1) ? 3 : 1, 1, (n > 1 && (n - 1) % 6 == 0) ? 1 : 0);
    end

    // T6: reset pulse in the middle of the sel=2 dwell
    reset_all();
    en_a = 1'b1; mask_a = 4'hF;
    for (int n = 1; n <= 12; n++) tick();
    chk_a("t6_pre", 12, 2, 1, 0);
    rst_a = 1'b1;
    tick();
    chk_a("t6_rst", 13, 0, 0, 0);
    chk("t6_rst_state", 13, int'(st_a), 0);
    rst_a = 1'b0;
    tick();
    chk_a("t6_restart", 14, 0, 1, 0);

    // Randomised run against the reference model on both instances
    reset_all();
    ma = mdl_reset();
    mb = mdl_reset();
    for (int n = 1; n <= 3000; n++) begin
      ra = ($urandom_range(0, 299) == 0);
      rb = ($urandom_range(0, 299) == 0);
      ea = ($urandom_range(0, 19) != 0);
      eb = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) mask_a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mask_b = 4'($urandom_range(0, 15));
      rst_a = ra; en_a = ea;
      rst_b = rb; en_b = eb;
      na = mdl_step(ma, ra, ea, mask_a, 4, 1);
      nb = mdl_step(mb, rb, eb, mask_b, 3, 0);
      tick();
      ma = na;
      mb = nb;
      chk_a("rnd_a", n, ma.sel, int'(ma.valid), int'(ma.fd));
      chk("rnd_a_state", n, int'(st_a), mdl_state(ma));
      chk_b("rnd_b", n, mb.sel, int'(mb.valid), int'(mb.fd));
      chk("rnd_b_state", n, int'(st_b), mdl_state(mb));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
